// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction BRAM read port, execute redirect
// request and the valid/ready hand-off of {inst, pc} towards decode.
interface fetch_if #(
    parameter int IMEM_AW = 14
);
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [31:0]        dec_inst;
    logic [31:0]        dec_pc;

    // Fetch unit side
    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_inst,
        output dec_pc
    );

    // Environment side: BRAM, execute and decode
    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_inst,
        input  dec_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency BRAM and
// buffers returned words in a 2-entry FIFO for decode. A FIFO slot is
// reserved for every read in flight, so the FIFO cannot overflow. A redirect
// from execute flushes the FIFO and the pending read and restarts at the
// target on the following cycle.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          IMEM_AW = 14
) (
    input  logic     clk,
    input  logic     rstn,
    fetch_if.master  bus
);

    logic [31:0]        fetch_pc_r;
    logic               inflight_r;
    logic [31:0]        inflight_pc_r;
    logic [31:0]        inst_mem_r [2];
    logic [31:0]        pc_mem_r   [2];
    logic               head_r;
    logic [1:0]         count_r;
    logic [IMEM_AW-1:0] addr_r;

    logic               dec_valid_s;
    logic               pop_s;
    logic               push_s;
    logic               issue_s;
    logic               tail_s;
    logic [2:0]         occ_s;
    logic [IMEM_AW-1:0] addr_s;
    logic               unused_s;

    // Byte-offset bits of the redirect target are ignored by design.
    assign unused_s = ^bus.redirect_pc[1:0];

    // Handshake, issue decision, FIFO pointers and output drive.
    always_comb begin
        dec_valid_s = 1'b0;
        issue_s     = 1'b0;
        push_s      = 1'b0;
        addr_s      = addr_r;

        if (rstn && (count_r != 2'd0) && !bus.redirect) begin
            dec_valid_s = 1'b1;
        end else begin
            dec_valid_s = 1'b0;
        end

        pop_s = dec_valid_s & bus.dec_ready;

        // Slots already committed after this cycle's pop; pop never exceeds count.
        occ_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

        if (rstn && !bus.redirect && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        if (rstn && inflight_r && !bus.redirect) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        // A push only happens with count 0 or 1, so the tail is head or head+1.
        tail_s = head_r ^ count_r[0];

        if (issue_s) begin
            addr_s = fetch_pc_r[IMEM_AW+1:2];
        end else begin
            addr_s = addr_r;
        end

        bus.imem_en   = issue_s;
        bus.imem_addr = addr_s;
        bus.dec_valid = dec_valid_s;
        if (rstn) begin
            bus.dec_inst = inst_mem_r[head_r];
            bus.dec_pc   = pc_mem_r[head_r];
        end else begin
            bus.dec_inst = 32'h0000_0000;
            bus.dec_pc   = 32'h0000_0000;
        end
    end

    // PC, in-flight tracking and FIFO state; redirect overrides everything but reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_r    <= PC_INIT;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            inst_mem_r[0] <= 32'h0000_0000;
            inst_mem_r[1] <= 32'h0000_0000;
            pc_mem_r[0]   <= 32'h0000_0000;
            pc_mem_r[1]   <= 32'h0000_0000;
            head_r        <= 1'b0;
            count_r       <= 2'd0;
            addr_r        <= '0;
        end else if (bus.redirect) begin
            fetch_pc_r <= {bus.redirect_pc[31:2], 2'b00};
            inflight_r <= 1'b0;
            head_r     <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + 32'd4;
                inflight_r    <= 1'b1;
                inflight_pc_r <= fetch_pc_r;
                addr_r        <= addr_s;
            end else begin
                inflight_r <= 1'b0;
            end

            if (push_s) begin
                inst_mem_r[tail_s] <= bus.imem_rdata;
                pc_mem_r[tail_s]   <= inflight_pc_r;
            end

            if (pop_s) begin
                head_r <= ~head_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference model works at the level
// of the fetch contract: after each restart (reset release or redirect) the
// stage issues sequential addresses from the target, delivers the matching
// {word, pc} stream in order, keeps dec_valid high from the third cycle on,
// and issues every cycle except when decode stalls once the pipe is primed.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;
    localparam int          AW      = 14;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    fetch_if #(.IMEM_AW(AW)) bus ();

    fetch_unit #(.PC_INIT(PC_INIT), .IMEM_AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;

    // Memory image: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    // Synchronous-read BRAM model; garbage when not enabled exposes bogus pushes.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= word_at(bus.imem_addr);
        else             bus.imem_rdata <= 32'hBAD0_0000 | ($urandom & 32'h0000_FFFF);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance it.
    task automatic tick();
        @(negedge clk);
        if (!rstn) begin
            check("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
            check("rst_imem_en",   32'(bus.imem_en),   32'h0);
            check("rst_dec_inst",  bus.dec_inst,       32'h0);
            check("rst_dec_pc",    bus.dec_pc,         32'h0);
        end else begin
            check("dec_valid", 32'(bus.dec_valid), 32'((cyc >= 2) && !bus.redirect));
            check("imem_en",   32'(bus.imem_en),
                  32'(!bus.redirect && ((cyc < 2) || bus.dec_ready)));
            if (bus.imem_en) begin
                check("imem_addr", 32'(bus.imem_addr), 32'(exp_fetch[AW+1:2]));
                exp_fetch = exp_fetch + 32'd4;
            end
            if (prev_stall) begin
                check("hold_pc",   bus.dec_pc,   prev_pc);
                check("hold_inst", bus.dec_inst, prev_inst);
            end
            if (bus.dec_valid && bus.dec_ready) begin
                check("dec_pc",   bus.dec_pc,   exp_pc);
                check("dec_inst", bus.dec_inst, word_at(exp_pc[AW+1:2]));
                exp_pc = exp_pc + 32'd4;
            end
        end
        prev_stall = rstn && bus.dec_valid && !bus.dec_ready;
        prev_pc    = bus.dec_pc;
        prev_inst  = bus.dec_inst;
        if (!rstn) begin
            cyc       = 0;
            exp_pc    = PC_INIT;
            exp_fetch = PC_INIT;
        end else if (bus.redirect) begin
            cyc       = 0;
            exp_pc    = {bus.redirect_pc[31:2], 2'b00};
            exp_fetch = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn            = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0000_0000;
        bus.dec_ready   = 1'b1;
        exp_pc          = PC_INIT;
        exp_fetch       = PC_INIT;

        // Reset, then streaming start from PC_INIT
        tick();
        tick();
        rstn = 1'b1;
        #1;
        check("first_addr", 32'(bus.imem_addr), 32'h0);
        repeat (3) tick();

        // Decode stall for five cycles, then release
        bus.dec_ready = 1'b0;
        repeat (5) tick();
        bus.dec_ready = 1'b1;
        repeat (4) tick();

        // Redirect with a full FIFO; target byte offset ignored
        bus.dec_ready = 1'b0;
        repeat (3) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        tick();
        bus.redirect  = 1'b0;
        bus.dec_ready = 1'b1;
        #1;
        check("redir_addr", 32'(bus.imem_addr), 32'h0000_0040);
        repeat (4) tick();

        // Back-to-back redirects: the second wins
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.redirect_pc = 32'h0000_0300;
        tick();
        bus.redirect = 1'b0;
        #1;
        check("b2b_addr", 32'(bus.imem_addr), 32'h0000_00C0);
        repeat (5) tick();

        // PC wrap across the top of the address space
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect = 1'b0;
        repeat (7) tick();

        // One-cycle reset with a full FIFO
        bus.dec_ready = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        rstn          = 1'b1;
        bus.dec_ready = 1'b1;
        repeat (5) tick();

        // Randomized traffic: stalls, redirects and rare resets
        for (int i = 0; i < 600; i++) begin
            int r;
            r               = int'($urandom_range(0, 99));
            rstn            = (r != 0);
            bus.redirect    = (r >= 1) && (r < 6);
            bus.redirect_pc = $urandom;
            bus.dec_ready   = ($urandom_range(0, 9) < 7);
            tick();
        end
        rstn          = 1'b1;
        bus.redirect  = 1'b0;
        bus.dec_ready = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
